// File: rtl/gpr_read_sched.sv
// Serialises the decoder's rs1/rs2 reads onto a single-read-port GPR file and returns both operands at once.
// Optional build macro: YSYX_23060201_GPR_X0_SKIP_EN (skip port reads of address 0, returning 0 instead).
module gpr_read_sched #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_ren,
    input  logic [ADDR_W-1:0] req_raddr1,
    input  logic [ADDR_W-1:0] req_raddr2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              gpr_en,
    output logic [ADDR_W-1:0] gpr_raddr,
    input  logic [DATA_W-1:0] gpr_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_reg,   state_next;
    logic [1:0]          pending_reg, pending_next;
    logic [2:0]          cnt_reg,     cnt_next;
    logic [ADDR_W-1:0]   raddr1_reg,  raddr1_next;
    logic [ADDR_W-1:0]   raddr2_reg,  raddr2_next;
    logic [DATA_W-1:0]   rdata1_reg,  rdata1_next;
    logic [DATA_W-1:0]   rdata2_reg,  rdata2_next;
    logic [1:0]          accept_pending;
    logic [1:0]          remaining;

    // Operands at address 0 can optionally be dropped at accept time.
`ifdef YSYX_23060201_GPR_X0_SKIP_EN
    assign accept_pending[0] = req_ren[0] && (req_raddr1 != '0);
    assign accept_pending[1] = req_ren[1] && (req_raddr2 != '0);
`else
    assign accept_pending    = req_ren;
`endif

    // rs1 is always served before rs2, so the bits left after this read follow directly.
    assign remaining = pending_reg[0] ? {pending_reg[1], 1'b0} : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            cnt_reg     <= '0;
            raddr1_reg  <= '0;
            raddr2_reg  <= '0;
            rdata1_reg  <= '0;
            rdata2_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            raddr1_reg  <= raddr1_next;
            raddr2_reg  <= raddr2_next;
            rdata1_reg  <= rdata1_next;
            rdata2_reg  <= rdata2_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        raddr1_next  = raddr1_reg;
        raddr2_next  = raddr2_reg;
        rdata1_next  = rdata1_reg;
        rdata2_next  = rdata2_reg;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        gpr_en       = 1'b0;
        gpr_raddr    = '0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    raddr1_next  = req_raddr1;
                    raddr2_next  = req_raddr2;
                    rdata1_next  = '0;
                    rdata2_next  = '0;
                    pending_next = accept_pending;
                    state_next   = (accept_pending != 2'b00) ? ISSUE : RESP;
                end
            end

            ISSUE: begin
                gpr_en     = 1'b1;
                gpr_raddr  = pending_reg[0] ? raddr1_reg : raddr2_reg;
                cnt_next   = 3'(RD_LAT);
                state_next = WAIT;
            end

            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                // Counter reaches 1 exactly RD_LAT cycles after the ISSUE cycle.
                if (cnt_reg == 3'd1) begin
                    if (pending_reg[0]) begin
                        rdata1_next = gpr_rdata;
                    end else begin
                        rdata2_next = gpr_rdata;
                    end
                    pending_next = remaining;
                    state_next   = (remaining != 2'b00) ? ISSUE : RESP;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rsp_rdata1 = rdata1_reg;
    assign rsp_rdata2 = rdata2_reg;

endmodule

// File: tb/tb_gpr_read_sched.sv
// Directed bench: two schedulers (RD_LAT=1 and RD_LAT=3) share the request stimulus, each with its own GPR port model.
module tb_gpr_read_sched;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_ren;
    logic [4:0]  req_raddr1;
    logic [4:0]  req_raddr2;

    logic        req_ready_s  [2];
    logic        rsp_valid_s  [2];
    logic        rsp_ready_s  [2];
    logic [31:0] rsp_rdata1_s [2];
    logic [31:0] rsp_rdata2_s [2];
    logic        gpr_en_s     [2];
    logic [4:0]  gpr_raddr_s  [2];
    logic [31:0] gpr_rdata_s  [2];

    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    gpr_read_sched #(.RD_LAT(1), .ADDR_W(5), .DATA_W(32)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_s[0]), .req_ren(req_ren),
        .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_rdata1(rsp_rdata1_s[0]), .rsp_rdata2(rsp_rdata2_s[0]),
        .gpr_en(gpr_en_s[0]), .gpr_raddr(gpr_raddr_s[0]), .gpr_rdata(gpr_rdata_s[0])
    );

    gpr_read_sched #(.RD_LAT(3), .ADDR_W(5), .DATA_W(32)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_s[1]), .req_ren(req_ren),
        .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_rdata1(rsp_rdata1_s[1]), .rsp_rdata2(rsp_rdata2_s[1]),
        .gpr_en(gpr_en_s[1]), .gpr_raddr(gpr_raddr_s[1]), .gpr_rdata(gpr_rdata_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPR port models: data is valid only in cycle T+RD_LAT, junk otherwise.
    logic        p1_v;
    logic [31:0] p1_d;
    logic        p3_v [3];
    logic [31:0] p3_d [3];

    always @(posedge clk) begin
        p1_v    <= gpr_en_s[0];
        p1_d    <= mem[gpr_raddr_s[0]];
        p3_v[0] <= gpr_en_s[1];
        p3_d[0] <= mem[gpr_raddr_s[1]];
        p3_v[1] <= p3_v[0];
        p3_d[1] <= p3_d[0];
        p3_v[2] <= p3_v[1];
        p3_d[2] <= p3_d[1];
    end

    assign gpr_rdata_s[0] = p1_v    ? p1_d    : 32'hBAD0_0001;
    assign gpr_rdata_s[1] = p3_v[2] ? p3_d[2] : 32'hBAD0_0003;

    typedef struct {
        logic [1:0]  ren;
        logic [4:0]  a1;
        logic [4:0]  a2;
        int          n;
        logic [4:0]  ea0;
        logic [4:0]  ea1;
        int          c2_l1;
        int          c2_l3;
        int          rsp_l1;
        int          rsp_l3;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] ren, input logic [4:0] a1, input logic [4:0] a2);
        req_valid  = 1'b1;
        req_ren    = ren;
        req_raddr1 = a1;
        req_raddr2 = a2;
    endtask

    // One request applied to both DUTs; outputs sampled #1 after each edge, cycle 0 = accept edge.
    task automatic run_txn(input int idx, input vec_t v);
        int          n_en  [2];
        logic [4:0]  en_a0 [2];
        logic [4:0]  en_a1 [2];
        int          en_c0 [2];
        int          en_c1 [2];
        int          rsp_c [2];
        logic [31:0] r1    [2];
        logic [31:0] r2    [2];
        bit          seen  [2];
        bit          rdy_bad [2];
        bit          adr_bad [2];
        int          cyc;
        for (int i = 0; i < 2; i++) begin
            n_en[i] = 0; en_a0[i] = '0; en_a1[i] = '0; en_c0[i] = 0; en_c1[i] = 0;
            rsp_c[i] = 0; r1[i] = '0; r2[i] = '0; seen[i] = 0; rdy_bad[i] = 0; adr_bad[i] = 0;
            chk($sformatf("v%0d_d%0d_req_ready_before", idx, i), 32'(req_ready_s[i]), 32'd1);
        end
        drive_req(v.ren, v.a1, v.a2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        do begin
            for (int i = 0; i < 2; i++) begin
                if (gpr_en_s[i]) begin
                    if (n_en[i] == 0) begin en_a0[i] = gpr_raddr_s[i]; en_c0[i] = cyc; end
                    else if (n_en[i] == 1) begin en_a1[i] = gpr_raddr_s[i]; en_c1[i] = cyc; end
                    n_en[i]++;
                end else if (gpr_raddr_s[i] != 5'd0) begin
                    adr_bad[i] = 1;
                end
                if (!seen[i]) begin
                    if (rsp_valid_s[i]) begin
                        seen[i] = 1; rsp_c[i] = cyc; r1[i] = rsp_rdata1_s[i]; r2[i] = rsp_rdata2_s[i];
                    end
                    if (req_ready_s[i]) rdy_bad[i] = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end while (cyc <= 30 && !(seen[0] && seen[1]));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("v%0d_d%0d_rsp_cycle", idx, i), 32'(rsp_c[i]), 32'((i == 0) ? v.rsp_l1 : v.rsp_l3));
            chk($sformatf("v%0d_d%0d_rdata1", idx, i), r1[i], v.d1);
            chk($sformatf("v%0d_d%0d_rdata2", idx, i), r2[i], v.d2);
            chk($sformatf("v%0d_d%0d_num_reads", idx, i), 32'(n_en[i]), 32'(v.n));
            if (v.n >= 1) begin
                chk($sformatf("v%0d_d%0d_read0_addr", idx, i), 32'(en_a0[i]), 32'(v.ea0));
                chk($sformatf("v%0d_d%0d_read0_cycle", idx, i), 32'(en_c0[i]), 32'd1);
            end
            if (v.n >= 2) begin
                chk($sformatf("v%0d_d%0d_read1_addr", idx, i), 32'(en_a1[i]), 32'(v.ea1));
                chk($sformatf("v%0d_d%0d_read1_cycle", idx, i), 32'(en_c1[i]), 32'((i == 0) ? v.c2_l1 : v.c2_l3));
            end
            chk($sformatf("v%0d_d%0d_req_ready_busy", idx, i), 32'(rdy_bad[i]), 32'd0);
            chk($sformatf("v%0d_d%0d_idle_raddr", idx, i), 32'(adr_bad[i]), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i);
        mem[0] = 32'h0;
        mem[3] = 32'h11;
        mem[5] = 32'hdeadbeef;
        mem[7] = 32'h22;
        mem[9] = 32'h99;

        //            ren    a1 a2 n ea0 ea1 c2L1 c2L3 rspL1 rspL3 d1            d2
        vecs[0] = '{2'b11, 5'd3, 5'd7, 2, 5'd3, 5'd7, 3, 5, 5, 9, 32'h11,       32'h22};
        vecs[1] = '{2'b01, 5'd5, 5'd7, 1, 5'd5, 5'd0, 0, 0, 3, 5, 32'hdeadbeef, 32'h0};
        vecs[2] = '{2'b00, 5'd3, 5'd7, 0, 5'd0, 5'd0, 0, 0, 1, 1, 32'h0,        32'h0};
        vecs[3] = '{2'b10, 5'd3, 5'd9, 1, 5'd9, 5'd0, 0, 0, 3, 5, 32'h0,        32'h99};
`ifdef YSYX_23060201_GPR_X0_SKIP_EN
        vecs[4] = '{2'b11, 5'd0, 5'd9, 1, 5'd9, 5'd0, 0, 0, 3, 5, 32'h0,        32'h99};
`else
        vecs[4] = '{2'b11, 5'd0, 5'd9, 2, 5'd0, 5'd9, 3, 5, 5, 9, 32'h0,        32'h99};
`endif
        vecs[5] = '{2'b11, 5'd7, 5'd7, 2, 5'd7, 5'd7, 3, 5, 5, 9, 32'h22,       32'h22};
        vecs[6] = '{2'b11, 5'd9, 5'd3, 2, 5'd9, 5'd3, 3, 5, 5, 9, 32'h99,       32'h11};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_ren = 2'b00;
        req_raddr1 = '0;
        req_raddr2 = '0;
        rsp_ready_s[0] = 1'b1;
        rsp_ready_s[1] = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_d%0d_rsp_valid", i), 32'(rsp_valid_s[i]), 32'd0);
            chk($sformatf("rst_d%0d_gpr_en", i), 32'(gpr_en_s[i]), 32'd0);
            chk($sformatf("rst_d%0d_gpr_raddr", i), 32'(gpr_raddr_s[i]), 32'd0);
            chk($sformatf("rst_d%0d_rdata1", i), rsp_rdata1_s[i], 32'd0);
            chk($sformatf("rst_d%0d_rdata2", i), rsp_rdata2_s[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("post_rst_d%0d_req_ready", i), 32'(req_ready_s[i]), 32'd1);

        // Table-driven transactions
        for (int k = 0; k < 7; k++) run_txn(k, vecs[k]);

        // Backpressure: both responses held for 4 cycles with rsp_ready low
        rsp_ready_s[0] = 1'b0;
        rsp_ready_s[1] = 1'b0;
        drive_req(2'b01, 5'd5, 5'd7);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int w = 0; w < 20 && !(rsp_valid_s[0] && rsp_valid_s[1]); w++) begin
            @(posedge clk); #1;
        end
        chk("bp_reach_resp", 32'({rsp_valid_s[0], rsp_valid_s[1]}), 32'b11);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("bp%0d_d%0d_rsp_valid", k, i), 32'(rsp_valid_s[i]), 32'd1);
                chk($sformatf("bp%0d_d%0d_rdata1", k, i), rsp_rdata1_s[i], 32'hdeadbeef);
                chk($sformatf("bp%0d_d%0d_rdata2", k, i), rsp_rdata2_s[i], 32'h0);
                chk($sformatf("bp%0d_d%0d_req_ready", k, i), 32'(req_ready_s[i]), 32'd0);
            end
            @(posedge clk); #1;
        end
        rsp_ready_s[0] = 1'b1;
        rsp_ready_s[1] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bp_done_d%0d_rsp_valid", i), 32'(rsp_valid_s[i]), 32'd0);
            chk($sformatf("bp_done_d%0d_req_ready", i), 32'(req_ready_s[i]), 32'd1);
        end
        run_txn(10, vecs[0]);

        // Asynchronous reset during the first read's WAIT
        drive_req(2'b11, 5'd3, 5'd7);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst_d%0d_gpr_en", i), 32'(gpr_en_s[i]), 32'd0);
            chk($sformatf("arst_d%0d_gpr_raddr", i), 32'(gpr_raddr_s[i]), 32'd0);
            chk($sformatf("arst_d%0d_rsp_valid", i), 32'(rsp_valid_s[i]), 32'd0);
            chk($sformatf("arst_d%0d_rdata1", i), rsp_rdata1_s[i], 32'd0);
            chk($sformatf("arst_d%0d_rdata2", i), rsp_rdata2_s[i], 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("late%0d_d%0d_gpr_en", k, i), 32'(gpr_en_s[i]), 32'd0);
                chk($sformatf("late%0d_d%0d_rsp_valid", k, i), 32'(rsp_valid_s[i]), 32'd0);
                chk($sformatf("late%0d_d%0d_rdata1", k, i), rsp_rdata1_s[i], 32'd0);
            end
        end
        run_txn(20, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
